// File: rtl/leve1_pkg.sv
// Shared types and constants for the LEVE1 decode stage: operation classes,
// base opcodes and the decoded-entry record carried in the output register.
package leve1_pkg;

    localparam int XLEN = 64;

    typedef enum logic [3:0] {
        OP_LUI     = 4'd0,
        OP_AUIPC   = 4'd1,
        OP_JAL     = 4'd2,
        OP_JALR    = 4'd3,
        OP_BRANCH  = 4'd4,
        OP_LOAD    = 4'd5,
        OP_STORE   = 4'd6,
        OP_OPIMM   = 4'd7,
        OP_OP      = 4'd8,
        OP_OPIMM32 = 4'd9,
        OP_OP32    = 4'd10,
        OP_MISCMEM = 4'd11,
        OP_SYSTEM  = 4'd12,
        OP_ILL     = 4'd13
    } op_t;

    localparam logic [6:0] OPC_LUI     = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
    localparam logic [6:0] OPC_JAL     = 7'b1101111;
    localparam logic [6:0] OPC_JALR    = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
    localparam logic [6:0] OPC_LOAD    = 7'b0000011;
    localparam logic [6:0] OPC_STORE   = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP      = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
    localparam logic [6:0] OPC_OP32    = 7'b0111011;
    localparam logic [6:0] OPC_MISCMEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;

    typedef struct packed {
        op_t             op;
        logic [2:0]      funct3;
        logic            alt;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic            rd_en;
        logic            rs1_en;
        logic            rs2_en;
        logic [XLEN-1:0] imm;
        logic            illegal;
    } dec_t;

endpackage

// File: rtl/leve1_id_if.sv
// Fetch-to-decode input handshake, decoded output handshake and the flush
// redirect, bundled for the decode stage (slave) and its environment (master).
interface leve1_id_if;
    import leve1_pkg::*;

    logic            flush;
    logic            ivalid;
    logic            iready;
    logic [XLEN-1:0] ipc;
    logic [31:0]     iinstr;

    logic            ovalid;
    logic            oready;
    logic [XLEN-1:0] opc;
    logic [31:0]     oinstr;
    op_t             oop;
    logic [2:0]      ofunct3;
    logic            oalt;
    logic [4:0]      ord;
    logic [4:0]      ors1;
    logic [4:0]      ors2;
    logic            ord_en;
    logic            ors1_en;
    logic            ors2_en;
    logic [XLEN-1:0] oimm;
    logic            oillegal;

    modport slave (
        input  flush, ivalid, ipc, iinstr, oready,
        output iready, ovalid, opc, oinstr, oop, ofunct3, oalt,
               ord, ors1, ors2, ord_en, ors1_en, ors2_en, oimm, oillegal
    );

    modport master (
        output flush, ivalid, ipc, iinstr, oready,
        input  iready, ovalid, opc, oinstr, oop, ofunct3, oalt,
               ord, ors1, ors2, ord_en, ors1_en, ors2_en, oimm, oillegal
    );

endinterface

// File: rtl/leve1_dec.sv
// Combinational RV64I classifier: instruction word to operation class,
// register indices/enables, sign-extended immediate and illegal flag.
module leve1_dec
    import leve1_pkg::*;
(
    input  logic [31:0] instr,
    output dec_t        dec
);

    logic [6:0]      opcode;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    op_t             op;
    logic            bad, rd_use, rs1_use, rs2_use;
    logic [XLEN-1:0] imm;

    assign opcode = instr[6:0];
    assign f3     = instr[14:12];
    assign f7     = instr[31:25];

    assign imm_i = {{(XLEN-12){instr[31]}}, instr[31:20]};
    assign imm_s = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{(XLEN-13){instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {{(XLEN-32){instr[31]}}, instr[31:12], 12'h000};
    assign imm_j = {{(XLEN-21){instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    always_comb begin
        op      = OP_ILL;
        bad     = 1'b0;
        rd_use  = 1'b0;
        rs1_use = 1'b0;
        rs2_use = 1'b0;
        imm     = '0;
        case (opcode)
            OPC_LUI:    begin op = OP_LUI;   rd_use = 1'b1; imm = imm_u; end
            OPC_AUIPC:  begin op = OP_AUIPC; rd_use = 1'b1; imm = imm_u; end
            OPC_JAL:    begin op = OP_JAL;   rd_use = 1'b1; imm = imm_j; end
            OPC_JALR: begin
                op = OP_JALR; rd_use = 1'b1; rs1_use = 1'b1; imm = imm_i;
                bad = (f3 != 3'd0);
            end
            OPC_BRANCH: begin
                op = OP_BRANCH; rs1_use = 1'b1; rs2_use = 1'b1; imm = imm_b;
                bad = (f3 == 3'd2) || (f3 == 3'd3);
            end
            OPC_LOAD: begin
                op = OP_LOAD; rd_use = 1'b1; rs1_use = 1'b1; imm = imm_i;
                bad = (f3 == 3'd7);
            end
            OPC_STORE: begin
                op = OP_STORE; rs1_use = 1'b1; rs2_use = 1'b1; imm = imm_s;
                bad = (f3 > 3'd3);
            end
            OPC_OPIMM: begin
                op = OP_OPIMM; rd_use = 1'b1; rs1_use = 1'b1; imm = imm_i;
                // 64-bit shifts use a 6-bit shamt, so only instr[31:26] is the selector
                bad = ((f3 == 3'd1) || (f3 == 3'd5)) &&
                      !((instr[31:26] == 6'h00) || (instr[31:26] == 6'h10));
            end
            OPC_OPIMM32: begin
                op = OP_OPIMM32; rd_use = 1'b1; rs1_use = 1'b1; imm = imm_i;
                bad = ((f3 == 3'd1) || (f3 == 3'd5)) && instr[25];
            end
            OPC_OP, OPC_OP32: begin
                op = (opcode == OPC_OP) ? OP_OP : OP_OP32;
                rd_use = 1'b1; rs1_use = 1'b1; rs2_use = 1'b1;
                bad = !((f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'd0) || (f3 == 3'd5))));
            end
            OPC_MISCMEM: begin op = OP_MISCMEM; imm = imm_i; end
            OPC_SYSTEM:  begin op = OP_SYSTEM; rd_use = (f3 != 3'd0); imm = imm_i; end
            default:     bad = 1'b1;
        endcase
        if (instr[1:0] != 2'b11) begin
            bad = 1'b1;
        end

        dec.op      = bad ? OP_ILL : op;
        dec.funct3  = f3;
        dec.alt     = instr[30];
        dec.rd      = instr[11:7];
        dec.rs1     = instr[19:15];
        dec.rs2     = instr[24:20];
        dec.rd_en   = !bad && rd_use && (instr[11:7] != 5'd0);
        dec.rs1_en  = !bad && rs1_use;
        dec.rs2_en  = !bad && rs2_use;
        dec.imm     = bad ? '0 : imm;
        dec.illegal = bad;
    end

endmodule

// File: rtl/leve1_id.sv
// LEVE1 decode stage: registered output entry plus a one-entry skid buffer of
// raw (PC, instruction) pairs so the upstream can run at full rate.
module leve1_id
    import leve1_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    leve1_id_if.slave  bus
);

    logic            o_valid_q, o_valid_d;
    logic [XLEN-1:0] o_pc_q, o_pc_d;
    logic [31:0]     o_instr_q, o_instr_d;
    dec_t            o_dec_q, o_dec_d;
    logic            s_valid_q, s_valid_d;
    logic [XLEN-1:0] s_pc_q, s_pc_d;
    logic [31:0]     s_instr_q, s_instr_d;

    logic            accept, drain, load_o;
    logic [XLEN-1:0] src_pc;
    logic [31:0]     src_instr;
    dec_t            src_dec;

    assign accept = bus.ivalid && !s_valid_q;
    assign drain  = o_valid_q && bus.oready;

    // A held skid entry is always older than anything upstream, so it wins the mux
    assign src_pc    = s_valid_q ? s_pc_q    : bus.ipc;
    assign src_instr = s_valid_q ? s_instr_q : bus.iinstr;

    leve1_dec u_dec (
        .instr (src_instr),
        .dec   (src_dec)
    );

    always_comb begin
        o_valid_d = o_valid_q;
        o_pc_d    = o_pc_q;
        o_instr_d = o_instr_q;
        o_dec_d   = o_dec_q;
        s_valid_d = s_valid_q;
        s_pc_d    = s_pc_q;
        s_instr_d = s_instr_q;
        load_o    = 1'b0;
        if (bus.flush) begin
            o_valid_d = 1'b0;
            s_valid_d = 1'b0;
        end else if (s_valid_q) begin
            if (drain) begin
                load_o    = 1'b1;
                s_valid_d = 1'b0;
            end
        end else if (!o_valid_q || drain) begin
            o_valid_d = accept;
            load_o    = accept;
        end else if (accept) begin
            s_valid_d = 1'b1;
            s_pc_d    = bus.ipc;
            s_instr_d = bus.iinstr;
        end
        if (load_o) begin
            o_valid_d = 1'b1;
            o_pc_d    = src_pc;
            o_instr_d = src_instr;
            o_dec_d   = src_dec;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_valid_q <= 1'b0;
            o_pc_q    <= '0;
            o_instr_q <= '0;
            o_dec_q   <= '0;
            s_valid_q <= 1'b0;
            s_pc_q    <= '0;
            s_instr_q <= '0;
        end else begin
            o_valid_q <= o_valid_d;
            o_pc_q    <= o_pc_d;
            o_instr_q <= o_instr_d;
            o_dec_q   <= o_dec_d;
            s_valid_q <= s_valid_d;
            s_pc_q    <= s_pc_d;
            s_instr_q <= s_instr_d;
        end
    end

    assign bus.iready   = !s_valid_q;
    assign bus.ovalid   = o_valid_q;
    assign bus.opc      = o_pc_q;
    assign bus.oinstr   = o_instr_q;
    assign bus.oop      = o_dec_q.op;
    assign bus.ofunct3  = o_dec_q.funct3;
    assign bus.oalt     = o_dec_q.alt;
    assign bus.ord      = o_dec_q.rd;
    assign bus.ors1     = o_dec_q.rs1;
    assign bus.ors2     = o_dec_q.rs2;
    assign bus.ord_en   = o_dec_q.rd_en;
    assign bus.ors1_en  = o_dec_q.rs1_en;
    assign bus.ors2_en  = o_dec_q.rs2_en;
    assign bus.oimm     = o_dec_q.imm;
    assign bus.oillegal = o_dec_q.illegal;

endmodule

// File: tb/tb_leve1_id.sv
// Bench for the LEVE1 decode stage: directed cases plus a randomized stream
// checked against an ordered queue of accepted entries and a rule-based decoder.
module tb_leve1_id;
    import leve1_pkg::*;

    localparam int W = 187;

    logic clk;
    logic rst;
    int   checks = 0;
    int   passes = 0;

    logic [95:0] exp_q[$];
    logic [6:0]  opcs[13] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23,
                              7'h13, 7'h33, 7'h1B, 7'h3B, 7'h0F, 7'h73};

    leve1_id_if bus ();

    leve1_id dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected output fields from the instruction-set rules; the mask drops the
    // immediate where the rules leave it unspecified (illegal, MISC-MEM, SYSTEM).
    function automatic void ref_vec(input logic [63:0] pc, input logic [31:0] in,
                                    output logic [W-1:0] v, output logic [W-1:0] m);
        op_t        op;
        bit         ill, urd, ur1, ur2, care;
        longint     imm;
        logic [2:0] f3;
        logic [6:0] f7;
        f3 = in[14:12]; f7 = in[31:25];
        op = OP_ILL; ill = 0; urd = 0; ur1 = 0; ur2 = 0; care = 1; imm = 0;
        case (in[6:0])
            7'h37: begin op = OP_LUI;   urd = 1; imm = $signed({in[31:12], 12'h000}); end
            7'h17: begin op = OP_AUIPC; urd = 1; imm = $signed({in[31:12], 12'h000}); end
            7'h6F: begin op = OP_JAL;   urd = 1; imm = $signed({in[31], in[19:12], in[20], in[30:21], 1'b0}); end
            7'h67: begin op = OP_JALR; urd = 1; ur1 = 1; imm = $signed(in[31:20]); ill = (f3 != 0); end
            7'h63: begin op = OP_BRANCH; ur1 = 1; ur2 = 1;
                         imm = $signed({in[31], in[7], in[30:25], in[11:8], 1'b0}); ill = (f3 == 2 || f3 == 3); end
            7'h03: begin op = OP_LOAD; urd = 1; ur1 = 1; imm = $signed(in[31:20]); ill = (f3 == 7); end
            7'h23: begin op = OP_STORE; ur1 = 1; ur2 = 1; imm = $signed({in[31:25], in[11:7]}); ill = (f3 > 3); end
            7'h13: begin op = OP_OPIMM; urd = 1; ur1 = 1; imm = $signed(in[31:20]);
                         ill = (f3 == 1 || f3 == 5) && !(in[31:26] == 6'h00 || in[31:26] == 6'h10); end
            7'h1B: begin op = OP_OPIMM32; urd = 1; ur1 = 1; imm = $signed(in[31:20]);
                         ill = (f3 == 1 || f3 == 5) && in[25]; end
            7'h33, 7'h3B: begin op = in[3] ? OP_OP32 : OP_OP; urd = 1; ur1 = 1; ur2 = 1;
                         ill = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 0 || f3 == 5))); end
            7'h0F: begin op = OP_MISCMEM; care = 0; end
            7'h73: begin op = OP_SYSTEM; urd = (f3 != 0); care = 0; end
            default: ill = 1;
        endcase
        if (in[1:0] != 2'b11) ill = 1;
        if (ill) begin op = OP_ILL; urd = 0; ur1 = 0; ur2 = 0; care = 0; end
        v = {pc, in, 4'(op), f3, in[30], in[11:7], in[19:15], in[24:20],
             urd && (in[11:7] != 5'd0), ur1, ur2, 64'(imm), ill};
        m = '1;
        if (!care) m[64:1] = '0;
    endfunction

    function automatic logic [W-1:0] dut_vec();
        return {bus.opc, bus.oinstr, 4'(bus.oop), bus.ofunct3, bus.oalt, bus.ord, bus.ors1,
                bus.ors2, bus.ord_en, bus.ors1_en, bus.ors2_en, bus.oimm, bus.oillegal};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        r = $urandom;
        if ($urandom_range(0, 7) != 0) r[6:0] = opcs[$urandom_range(0, 12)];
        case ($urandom_range(0, 3))
            0: r[31:25] = 7'h00;
            1: r[31:25] = 7'h20;
            default: ;
        endcase
        return r;
    endfunction

    // Advances one clock and applies the transfer rules to the expected queue.
    task automatic tick();
        bit acc, drn, kill;
        kill = bus.flush || rst;
        acc  = bus.ivalid && (exp_q.size() < 2);
        drn  = (exp_q.size() > 0) && bus.oready;
        @(posedge clk);
        #1;
        if (kill) exp_q.delete();
        else begin
            if (drn) void'(exp_q.pop_front());
            if (acc) exp_q.push_back({bus.ipc, bus.iinstr});
        end
    endtask

    task automatic test_reset();
        checks++; if (bus.ovalid !== 1'b0) $display("FAIL reset_ovalid got %b want 0", bus.ovalid); else passes++;
        checks++; if (bus.iready !== 1'b1) $display("FAIL reset_iready got %b want 1", bus.iready); else passes++;
        checks++; if (dut_vec() !== '0) $display("FAIL reset_data got %h want 0", dut_vec()); else passes++;
    endtask

    task automatic test_decode();
        logic [31:0] tbl[6] = '{32'h00500093, 32'h0080006F, 32'hFE000EE3,
                                32'h00000000, 32'h40001033, 32'h02000033};
        logic [W-1:0] ev, em;
        bus.oready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.ivalid = 1'b1;
            bus.ipc    = 64'h8000_0000 + 64'(4 * i);
            bus.iinstr = tbl[i];
            tick();
            checks++; if (bus.ovalid !== 1'b1) $display("FAIL dec_ovalid[%0d] got %b want 1", i, bus.ovalid); else passes++;
            if (exp_q.size() > 0) begin
                ref_vec(exp_q[0][95:32], exp_q[0][31:0], ev, em);
                $display("txn pc=%h instr=%h op=%0d ill=%0b", bus.opc, bus.oinstr, bus.oop, bus.oillegal);
                checks++; if ((dut_vec() & em) !== (ev & em)) $display("FAIL dec_model[%0d] got %h want %h", i, dut_vec() & em, ev & em); else passes++;
            end
            case (i)
                0: begin
                    checks++; if ({bus.oop, bus.ord, bus.ors1, bus.ord_en, bus.ors2_en} !== {OP_OPIMM, 5'd1, 5'd0, 1'b1, 1'b0})
                        $display("FAIL addi_fields got %h/%0d/%0d/%b/%b want OPIMM/1/0/1/0", bus.oop, bus.ord, bus.ors1, bus.ord_en, bus.ors2_en); else passes++;
                    checks++; if (bus.oimm !== 64'd5) $display("FAIL addi_imm got %h want 5", bus.oimm); else passes++;
                end
                1: begin
                    checks++; if ({bus.oop, bus.oimm, bus.ord_en} !== {OP_JAL, 64'd8, 1'b0})
                        $display("FAIL jal_fields got %h/%h/%b want JAL/8/0", bus.oop, bus.oimm, bus.ord_en); else passes++;
                end
                2: begin
                    checks++; if ({bus.oop, bus.oimm} !== {OP_BRANCH, 64'hFFFF_FFFF_FFFF_FFFC})
                        $display("FAIL beq_fields got %h/%h want BRANCH/fffffffffffffffc", bus.oop, bus.oimm); else passes++;
                end
                default: begin
                    checks++; if ({bus.oop, bus.oillegal, bus.ord_en, bus.ors1_en, bus.ors2_en} !== {OP_ILL, 4'b1000})
                        $display("FAIL ill_fields[%0d] got %h/%b want ILL/1 en=0", i, bus.oop, bus.oillegal); else passes++;
                end
            endcase
        end
        bus.ivalid = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] ia, ib, ic;
        ia = 32'h00108113; ib = 32'h002081B3; ic = 32'h00312023;
        bus.oready = 1'b0;
        bus.ivalid = 1'b1; bus.ipc = 64'h100; bus.iinstr = ia;
        tick();
        checks++; if (bus.iready !== 1'b1) $display("FAIL b2b_iready_after_1 got %b want 1", bus.iready); else passes++;
        bus.ipc = 64'h104; bus.iinstr = ib;
        tick();
        checks++; if (bus.iready !== 1'b0) $display("FAIL b2b_iready_after_2 got %b want 0", bus.iready); else passes++;
        bus.ipc = 64'h108; bus.iinstr = ic;
        tick();
        checks++; if ({bus.ovalid, bus.oinstr, bus.iready} !== {1'b1, ia, 1'b0})
            $display("FAIL b2b_stall got v=%b instr=%h rdy=%b want 1/%h/0", bus.ovalid, bus.oinstr, bus.iready, ia); else passes++;
        bus.oready = 1'b1;
        tick();
        checks++; if ({bus.ovalid, bus.oinstr, bus.opc} !== {1'b1, ib, 64'h104})
            $display("FAIL b2b_second got v=%b instr=%h want 1/%h", bus.ovalid, bus.oinstr, ib); else passes++;
        $display("txn pc=%h instr=%h op=%0d ill=%0b", bus.opc, bus.oinstr, bus.oop, bus.oillegal);
        tick();
        checks++; if ({bus.ovalid, bus.oinstr, bus.opc} !== {1'b1, ic, 64'h108})
            $display("FAIL b2b_third got v=%b instr=%h want 1/%h", bus.ovalid, bus.oinstr, ic); else passes++;
        $display("txn pc=%h instr=%h op=%0d ill=%0b", bus.opc, bus.oinstr, bus.oop, bus.oillegal);
        bus.ivalid = 1'b0;
        tick();
        checks++; if (bus.ovalid !== 1'b0) $display("FAIL b2b_empty got %b want 0", bus.ovalid); else passes++;
    endtask

    task automatic test_flush();
        bus.oready = 1'b0; bus.ivalid = 1'b1;
        bus.ipc = 64'h200; bus.iinstr = 32'h00100093;
        tick();
        bus.ipc = 64'h204; bus.iinstr = 32'h00200113;
        tick();
        checks++; if (bus.iready !== 1'b0) $display("FAIL flush_full got %b want 0", bus.iready); else passes++;
        bus.flush = 1'b1; bus.ipc = 64'h208; bus.iinstr = 32'h00300193;
        tick();
        bus.flush = 1'b0;
        checks++; if ({bus.ovalid, bus.iready} !== 2'b01) $display("FAIL flush_full_clear got v=%b r=%b want 0/1", bus.ovalid, bus.iready); else passes++;
        bus.ipc = 64'h20C; bus.iinstr = 32'h00400213;
        tick();
        checks++; if (bus.iready !== 1'b1) $display("FAIL flush_one_ready got %b want 1", bus.iready); else passes++;
        bus.flush = 1'b1; bus.ipc = 64'h210; bus.iinstr = 32'h00500293;
        tick();
        bus.flush = 1'b0; bus.ivalid = 1'b0; bus.oready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (bus.ovalid !== 1'b0) $display("FAIL flush_dropped[%0d] got v=%b pc=%h want 0", i, bus.ovalid, bus.opc); else passes++;
            tick();
        end
    endtask

    task automatic test_async_reset();
        logic [W-1:0] ev, em;
        bus.oready = 1'b1; bus.ivalid = 1'b1;
        bus.ipc = 64'h300; bus.iinstr = 32'h00100093;
        tick();
        bus.oready = 1'b0; bus.ipc = 64'h304; bus.iinstr = 32'h00200113;
        tick();
        #2 rst = 1'b1;
        #1;
        checks++; if ({bus.ovalid, bus.iready} !== 2'b01) $display("FAIL async_rst got v=%b r=%b want 0/1", bus.ovalid, bus.iready); else passes++;
        tick();
        rst = 1'b0; bus.oready = 1'b1;
        bus.ipc = 64'h400; bus.iinstr = 32'h00A00113;
        tick();
        checks++; if ({bus.ovalid, bus.oop, bus.ord, bus.oimm} !== {1'b1, OP_OPIMM, 5'd2, 64'd10})
            $display("FAIL post_rst got v=%b op=%h rd=%0d imm=%h want 1/OPIMM/2/a", bus.ovalid, bus.oop, bus.ord, bus.oimm); else passes++;
        if (exp_q.size() > 0) begin
            ref_vec(exp_q[0][95:32], exp_q[0][31:0], ev, em);
            checks++; if ((dut_vec() & em) !== (ev & em)) $display("FAIL post_rst_model got %h want %h", dut_vec() & em, ev & em); else passes++;
        end
        bus.ivalid = 1'b0;
        tick();
    endtask

    task automatic test_random();
        logic [W-1:0] ev, em, prev;
        bit hold;
        hold = 0; prev = '0;
        for (int n = 0; n < 600; n++) begin
            bus.ivalid = ($urandom_range(0, 9) < 7);
            bus.ipc    = {$urandom, $urandom};
            bus.iinstr = rand_instr();
            bus.oready = ($urandom_range(0, 9) < 6);
            bus.flush  = ($urandom_range(0, 39) == 0);
            checks++; if ({bus.ovalid, bus.iready} !== {exp_q.size() > 0, exp_q.size() < 2})
                $display("FAIL rnd_hs[%0d] got v=%b r=%b want %b/%b", n, bus.ovalid, bus.iready, exp_q.size() > 0, exp_q.size() < 2); else passes++;
            if (exp_q.size() > 0) begin
                ref_vec(exp_q[0][95:32], exp_q[0][31:0], ev, em);
                checks++; if ((dut_vec() & em) !== (ev & em)) $display("FAIL rnd_data[%0d] got %h want %h", n, dut_vec() & em, ev & em); else passes++;
                if (bus.oready && !bus.flush)
                    $display("txn pc=%h instr=%h op=%0d ill=%0b", bus.opc, bus.oinstr, bus.oop, bus.oillegal);
            end
            if (hold) begin
                checks++; if (dut_vec() !== prev) $display("FAIL rnd_stable[%0d] got %h want %h", n, dut_vec(), prev); else passes++;
            end
            hold = (exp_q.size() > 0) && !bus.oready && !bus.flush;
            prev = dut_vec();
            tick();
        end
        bus.ivalid = 1'b0; bus.flush = 1'b0; bus.oready = 1'b1;
        tick(); tick();
        checks++; if (bus.ovalid !== 1'b0) $display("FAIL rnd_drain got %b want 0", bus.ovalid); else passes++;
    endtask

    initial begin
        rst = 1'b1;
        bus.flush = 1'b0; bus.ivalid = 1'b0; bus.ipc = '0; bus.iinstr = '0; bus.oready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b0;
        tick();
        test_decode();
        test_back_to_back();
        test_flush();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/leve1_id.md
# leve1_id

Decode stage of the LEVE1 RV64I pipeline, directly downstream of instruction fetch. Accepts one (PC, instruction) pair per cycle over a valid/ready handshake and classifies it into an operation class. Extracts register indices and the sign-extended immediate, and flags illegal encodings. Results go through a registered output stage backed by a one-entry skid buffer, so full throughput is kept under backpressure.

## Interface
- `XLEN`, 64: datapath width.
- `CLK` in 1: clock.
- `RST` in 1: reset. One clock; reset is asynchronous and active-high.
- `FLUSH` in 1: redirect from execute. Discards all held entries.
- `IVALID` in 1: upstream entry valid.
- `IREADY` out 1: stage can accept an entry.
- `IPC` in XLEN: PC of the entry.
- `IINSTR` in 32: instruction word.
- `OVALID` out 1: decoded entry valid.
- `OREADY` in 1: downstream accepts.
- `OPC` out XLEN: passed-through PC.
- `OINSTR` out 32: passed-through instruction.
- `OOP` out 4: operation class, type `op_t`.
- `OFUNCT3` out 3: instr[14:12].
- `OALT` out 1: instr[30] (SUB/SRA select).
- `ORD`, `ORS1`, `ORS2` out 5 each: register indices.
- `ORD_EN`, `ORS1_EN`, `ORS2_EN` out 1 each: index is used. `ORD_EN` is 0 when rd=x0.
- `OIMM` out XLEN: sign-extended immediate; 0 for R-type.
- `OILLEGAL` out 1: illegal encoding. The entry is still delivered with `OVALID`.

## Operation
- `op_t` values: `OP_LUI`, `OP_AUIPC`, `OP_JAL`, `OP_JALR`, `OP_BRANCH`, `OP_LOAD`, `OP_STORE`, `OP_OPIMM`, `OP_OP`, `OP_OPIMM32`, `OP_OP32`, `OP_MISCMEM`, `OP_SYSTEM`, `OP_ILL`.
- Immediate formats:
  - I-type: {instr[31:20]}.
  - S-type: {instr[31:25], instr[11:7]}.
  - B-type: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U-type: {instr[31:12], 12'h0}.
  - J-type: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - All formats are sign-extended from the top instruction bit to XLEN.
- Illegal conditions. Any of these forces `OOP=OP_ILL`, `OILLEGAL=1` and all `*_EN=0`:
  - instr[1:0]≠2'b11;
  - unknown opcode;
  - JALR with funct3≠0;
  - BRANCH with funct3 of 2 or 3;
  - LOAD with funct3=7;
  - STORE with funct3>3;
  - OP/OP32 with funct7 not in {0x00, 0x20}, or 0x20 with funct3 not in {0, 5};
  - SLLI/SRLI/SRAI with instr[31:26] not in {0x00, 0x10};
  - *IW shifts with instr[25]=1.
- M extension is out of scope: funct7=0x01 is illegal.
- Register enables:
  - rs1 is used by JALR, BRANCH, LOAD, STORE, OPIMM*, OP*.
  - rs2 is used by BRANCH, STORE, OP*.
  - rd is used by all classes except BRANCH, STORE, MISCMEM, and SYSTEM with funct3=0.
- Buffering:
  - Output register `O`: valid bit plus all O* fields.
  - Skid register `S`: holds one raw (PC, INSTR) entry.
  - Decoding is combinational on the source being loaded into `O`.
  - `IREADY = !S.valid`, a registered signal.
- Per-cycle rules. Accept means `IVALID && IREADY`; drain means `OVALID && OREADY`:
  - `O` empty or draining, `S` empty: accepted input loads `O`.
  - `O` full and not draining: accepted input loads `S`.
  - Draining with `S` full: `S` moves to `O`, `S` clears. Upstream is not ready that cycle.
- `FLUSH` has priority over every other update. Next cycle `O.valid=0` and `S.valid=0`. Input presented in the flush cycle is dropped, even if `IREADY` was high.
- Entries leave in acceptance order; none is lost or duplicated.

## Timing
- Reset values:
  - `OVALID=0`, `IREADY=1`, `S.valid=0`.
  - All data outputs 0, so `OOP` is the encoding 0 (`OP_LUI`), but it is don't-care while `OVALID=0`.
- Latency: an entry accepted in cycle n is visible on `O*` in cycle n+1.
- Throughput: one entry per cycle while `OREADY=1`.
- Handshake rules:
  - `O*` must hold stable while `OVALID && !OREADY`.
  - `OVALID` never drops without a drain or `FLUSH`.
- Reset asserted mid-stream clears both registers immediately, asynchronously.

## Structure
- `leve1_pkg` holds:
  - `op_t` enum (4 bits);
  - opcode constants (`OPC_LUI` = 7'b0110111 … `OPC_SYSTEM` = 7'b1110011);
  - `dec_t` packed struct (op, funct3, alt, rd/rs1/rs2, enables, imm, illegal).
- Sub-module `leve1_dec`: purely combinational {instr} -> `dec_t`. It is instantiated once, on the mux output feeding `O`.

## Test plan
- `IINSTR=0x00500093` (addi x1,x0,5), `OREADY=1` -> next cycle `OOP=OP_OPIMM`, `ORD=1`, `ORS1=0`, `OIMM=5`, `ORD_EN=1`, `ORS2_EN=0`.
- `0x0080006F` (jal x0,+8), then `0xFE000EE3` (beq x0,x0,-4) -> first: `OP_JAL`, `OIMM=8`, `ORD_EN=0`; second: `OP_BRANCH`, `OIMM=0xFFFF_FFFF_FFFF_FFFC`.
- `0x00000000`, `0x40001033` (funct3=1 with alt) and `0x02000033` (mul) -> each `OILLEGAL=1`, `OOP=OP_ILL`, `OVALID=1`.
- Stream 3 entries back to back with `OREADY=0` for 2 cycles:
  - `IREADY` falls after the second entry is accepted.
  - After release, all 3 appear in order with no bubble between entries 1 and 2.
- `FLUSH` while `O` and `S` are full -> next cycle `OVALID=0`, `IREADY=1`; the input presented in the flush cycle never appears.
- Assert `RST` mid-stream asynchronously -> `OVALID=0` and `IREADY=1` before the next edge; the first entry after release decodes correctly.
